nibble_symbolizer: RTL and testbench

- Transmit-side stage directly upstream of the modulator core.
- Accepts 4-bit data nibbles from the FPGA bus with a valid/ready handshake and buffers them in a small FIFO.
- Slices each nibble into 1-, 2- or 4-bit symbols according to the modulation select.
- Emits one symbol per symbol period on the modulator's 4-bit data input, with a one-cycle valid strobe.

---
 rtl/nibble_symbolizer_if.sv | 24 ++
 rtl/nibble_symbolizer.sv | 168 ++++++++++++++++
 tb/tb_nibble_symbolizer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_symbolizer_if.sv
// rtl/nibble_symbolizer_if.sv - nibble input handshake and symbol output bundle for nibble_symbolizer
interface nibble_symbolizer_if;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       nib_ready;
    logic [3:0] sym_out;
    logic       sym_valid;

    modport master (
        output nib_in,
        output nib_valid,
        input  nib_ready,
        input  sym_out,
        input  sym_valid
    );

    modport slave (
        input  nib_in,
        input  nib_valid,
        output nib_ready,
        output sym_out,
        output sym_valid
    );
endinterface

// File: rtl/nibble_symbolizer.sv
// rtl/nibble_symbolizer.sv - nibble FIFO plus 1/2/4-bit symbol slicer paced by a symbol-period divider
// Optional Gray mapping of emitted symbols when SYM_GRAY_EN is defined.
module nibble_symbolizer #(
    parameter int FIFO_DEPTH = 8,
    parameter int SYM_DIV    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [1:0]                    mod_sel,
    nibble_symbolizer_if.slave            bus,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SYM_DIV);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_div;
    logic [1:0]    r_state;
    logic [1:0]    r_k;
    logic [1:0]    r_rem;
    logic [3:0]    r_nib;
    logic [3:0]    r_sym;
    logic          r_sym_valid;
    logic          r_under;
    logic          r_en_d;

    logic          w_full;
    logic          w_push;
    logic          w_tick;
    logic          w_load;
    logic          w_pop;
    logic          w_shift;
    logic          w_emit;
    logic [1:0]    w_k;
    logic [3:0]    w_nib;
    logic [3:0]    w_slice;
    logic [3:0]    w_sym;
    logic [3:0]    w_nib_next;
    logic [1:0]    w_rem_load;

    assign w_full  = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_push  = bus.nib_valid && !w_full;
    assign w_tick  = enable && (r_div == DW'(SYM_DIV - 1));
    assign w_load  = w_tick && (r_state == S_WAIT);
    assign w_pop   = w_load && (r_level != '0);
    assign w_shift = w_tick && (r_state == S_ACTIVE);
    assign w_emit  = w_pop || w_shift;

    // k code: 0 = 1 bit, 1 = 2 bits, 2 = 4 bits; mod_sel only matters at nibble load
    assign w_k   = w_pop ? (mod_sel[1] ? 2'd2 : {1'b0, mod_sel[0]}) : r_k;
    assign w_nib = w_pop ? r_mem[r_rd_ptr] : r_nib;

    always_comb begin
        w_slice    = w_nib;
        w_nib_next = 4'd0;
        w_rem_load = 2'd0;
        case (w_k)
            2'd0: begin
                w_slice    = {3'b000, w_nib[3]};
                w_nib_next = {w_nib[2:0], 1'b0};
                w_rem_load = 2'd3;
            end
            2'd1: begin
                w_slice    = {2'b00, w_nib[3:2]};
                w_nib_next = {w_nib[1:0], 2'b00};
                w_rem_load = 2'd1;
            end
            default: begin
                w_slice    = w_nib;
                w_nib_next = 4'd0;
                w_rem_load = 2'd0;
            end
        endcase
    end

`ifdef SYM_GRAY_EN
    // Upper bits of the slice are zero, so a full-width shift stays within k bits
    assign w_sym = w_slice ^ (w_slice >> 1);
`else
    assign w_sym = w_slice;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.nib_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_div <= '0;
        else if (!enable) r_div <= '0;
        else if (w_tick)  r_div <= '0;
        else              r_div <= r_div + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            r_rem   <= 2'd0;
            r_nib   <= 4'd0;
        end else if (!enable) begin
            r_state <= S_IDLE;
            r_rem   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_pop) begin
                        r_nib   <= w_nib_next;
                        r_k     <= w_k;
                        r_rem   <= w_rem_load;
                        r_state <= (w_rem_load != 2'd0) ? S_ACTIVE : S_WAIT;
                    end
                end
                S_ACTIVE: begin
                    if (w_shift) begin
                        r_nib <= w_nib_next;
                        r_rem <= r_rem - 2'd1;
                        if (r_rem == 2'd1) r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym       <= 4'd0;
            r_sym_valid <= 1'b0;
            r_under     <= 1'b0;
            r_en_d      <= 1'b0;
        end else begin
            r_sym_valid <= w_emit;
            if (w_emit) r_sym <= w_sym;
            if (enable && !r_en_d)          r_under <= 1'b0;
            else if (w_load && !w_pop)      r_under <= 1'b1;
            r_en_d <= enable;
        end
    end

    assign bus.nib_ready = !w_full;
    assign bus.sym_out   = r_sym;
    assign bus.sym_valid = r_sym_valid;
    assign underrun      = r_under;
    assign fifo_level    = r_level;
endmodule

// File: tb/tb_nibble_symbolizer.sv
// tb/tb_nibble_symbolizer.sv - randomized self-checking bench for nibble_symbolizer against a symbol-queue model
module tb_nibble_symbolizer;
    localparam int DEPTH = 8;
    localparam int DIV   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mod_sel = 2'b00;
    logic       underrun;
    logic [3:0] fifo_level;

    nibble_symbolizer_if bus_if ();

    nibble_symbolizer #(.FIFO_DEPTH(DEPTH), .SYM_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mod_sel    (mod_sel),
        .bus        (bus_if),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_sym(input int b);
`ifdef SYM_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    int m_fifo[$];
    int m_pend[$];
    int m_cnt, m_sym, m_valid, m_under, m_en_d;
    int dut_syms[$];

    // Model: symbol list per nibble, FIFO as a queue, divider as a plain counter
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_fifo.delete(); m_pend.delete();
                m_cnt = 0; m_sym = 0; m_valid = 0; m_under = 0; m_en_d = 0;
            end else begin
                int nv, ni, ms, en;
                bit push;
                nv = bus_if.nib_valid; ni = bus_if.nib_in; ms = mod_sel; en = enable;
                push = nv && (m_fifo.size() < DEPTH);
                m_valid = 0;
                if (!en) begin
                    m_pend.delete();
                    m_cnt = 0;
                end else begin
                    if (!m_en_d) m_under = 0;
                    if (m_cnt == DIV - 1) begin
                        m_cnt = 0;
                        if (m_pend.size() > 0) begin
                            m_sym = m_pend.pop_front(); m_valid = 1;
                        end else if (m_fifo.size() > 0) begin
                            int nib, k;
                            nib = m_fifo.pop_front();
                            k = ms[1] ? 4 : (ms[0] ? 2 : 1);
                            for (int i = 0; i < 4 / k; i++)
                                m_pend.push_back(map_sym((nib >> (4 - k * (i + 1))) & ((1 << k) - 1)));
                            m_sym = m_pend.pop_front(); m_valid = 1;
                        end else begin
                            m_under = 1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
                if (push) m_fifo.push_back(ni);
                m_en_d = en;
            end
            #1;
            chk("sym_valid", int'(bus_if.sym_valid), m_valid);
            chk("sym_out", int'(bus_if.sym_out), m_sym);
            chk("underrun", int'(underrun), m_under);
            chk("fifo_level", int'(fifo_level), m_fifo.size());
            chk("nib_ready", int'(bus_if.nib_ready), int'(m_fifo.size() < DEPTH));
            if (rst_n && bus_if.sym_valid) dut_syms.push_back(int'(bus_if.sym_out));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int v);
        bus_if.nib_in = v[3:0]; bus_if.nib_valid = 1'b1;
        @(negedge clk);
        bus_if.nib_valid = 1'b0;
    endtask

    task automatic chk_syms(input string name, input int exp[$]);
        chk({name, "_count"}, dut_syms.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_syms.size(); i++)
            chk(name, dut_syms[i], exp[i]);
    endtask

    initial begin
        int e[$];
        bus_if.nib_in = 4'd0; bus_if.nib_valid = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("reset_ready", int'(bus_if.nib_ready), 1);
        chk("reset_level", int'(fifo_level), 0);

        // BPSK: 4'hA -> 1,0,1,0 then underrun on the fifth tick
        mod_sel = 2'b00;
        push(4'hA);
        dut_syms.delete();
        enable = 1'b1;
        cyc(22);
        e = '{1, 0, 1, 0};
        chk_syms("bpsk", e);
        chk("bpsk_underrun", int'(underrun), 1);

        // QPSK: B, 6; re-enable clears underrun
        enable = 1'b0; cyc(1);
        chk("underrun_sticky_disabled", int'(underrun), 1);
        mod_sel = 2'b01;
        push(4'hB); push(4'h6);
        dut_syms.delete();
        enable = 1'b1;
        cyc(2);
        chk("underrun_cleared", int'(underrun), 0);
        cyc(16);
`ifdef SYM_GRAY_EN
        e = '{3, 2, 1, 3};
`else
        e = '{2, 3, 1, 2};
`endif
        chk_syms("qpsk", e);

        // 16QAM 5, C then mod_sel -> BPSK for 9
        enable = 1'b0; mod_sel = 2'b10;
        push(4'h5); push(4'hC); push(4'h9);
        dut_syms.delete();
        enable = 1'b1;
        cyc(9);
        mod_sel = 2'b00;
        cyc(22);
`ifdef SYM_GRAY_EN
        e = '{7, 10, 1, 0, 0, 1};
`else
        e = '{5, 12, 1, 0, 0, 1};
`endif
        chk_syms("qam_switch", e);
        chk("qam_underrun", int'(underrun), 1);

        // Abort mid-QPSK nibble: second half of D dropped, resume with 7
        enable = 1'b0; mod_sel = 2'b01;
        push(4'hD); push(4'h7);
        dut_syms.delete();
        enable = 1'b1;
        cyc(5);
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(1);
        chk("abort_underrun_cleared", int'(underrun), 0);
        cyc(10);
`ifdef SYM_GRAY_EN
        e = '{2, 1, 2};
`else
        e = '{3, 1, 3};
`endif
        chk_syms("abort", e);

        // Full FIFO, then simultaneous push/pop at level 3
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_if.nib_in = 4'(i); bus_if.nib_valid = 1'b1;
            @(negedge clk);
        end
        bus_if.nib_valid = 1'b0;
        chk("full_level", int'(fifo_level), 8);
        chk("full_ready", int'(bus_if.nib_ready), 0);
        mod_sel = 2'b10;
        enable = 1'b1;
        cyc(23);
        chk("level_before_pushpop", int'(fifo_level), 3);
        bus_if.nib_in = 4'h3; bus_if.nib_valid = 1'b1;
        cyc(1);
        bus_if.nib_valid = 1'b0;
        chk("level_after_pushpop", int'(fifo_level), 3);

        // Random traffic with enable toggles and one asynchronous reset
        for (int c = 0; c < 2500; c++) begin
            bus_if.nib_valid = ($urandom_range(0, 3) == 0);
            bus_if.nib_in    = 4'($urandom);
            if ($urandom_range(0, 40) == 0) mod_sel = 2'($urandom);
            if ($urandom_range(0, 150) == 0) enable = ~enable;
            if (c == 1200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_sym_out", int'(bus_if.sym_out), 0);
                chk("async_sym_valid", int'(bus_if.sym_valid), 0);
                chk("async_underrun", int'(underrun), 0);
                chk("async_level", int'(fifo_level), 0);
                chk("async_ready", int'(bus_if.nib_ready), 1);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        bus_if.nib_valid = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
